// File: rtl/onoff_pkg.sv
// ---- onoff_pkg: shared state encoding and parameter rules for ON/OFF arbiters (rev 1.0) ----
`default_nettype none

package onoff_pkg;

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_ON  = 2'd1,
    S_GAP = 2'd2
  } state_t;

  localparam int N_MIN = 2;
  localparam int N_MAX = 16;

  function automatic bit params_legal(input int n, input int min_on, input int max_on, input int gap);
    return (n >= N_MIN) && (n <= N_MAX) && (min_on >= 1) && (max_on >= 0) &&
           ((max_on == 0) || (max_on >= min_on)) && (gap >= 0);
  endfunction

  // Bits needed to hold the values 0..v-1; never narrower than one bit.
  function automatic int cnt_width(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ---- rr_pick: combinational round-robin picker, first set bit at or after ptr (rev 1.0) ----
`default_nettype none

module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [N-1:0] rot;
  logic [IW:0]  off;
  logic [IW:0]  sum;

  always_comb begin
    // Rotating the doubled vector puts requester ptr at bit 0.
    rot   = N'({req, req} >> ptr);
    valid = 1'b0;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        off   = (IW + 1)'(k);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IW + 1)'(N)) begin
      sum = sum - (IW + 1)'(N);
    end
    idx    = sum[IW-1:0];
    onehot = valid ? (N'(1) << idx) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/onoff_rr_arbiter.sv
// ---- onoff_rr_arbiter: round-robin arbiter with min/max on-time and off-gap (rev 1.0) ----
`default_nettype none

module onoff_rr_arbiter
  import onoff_pkg::*;
#(
  parameter int N      = 4,
  parameter int MIN_ON = 3,
  parameter int MAX_ON = 8,
  parameter int GAP    = 2,
  parameter int IW     = $clog2(N)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          out,
  output logic          busy,
  output logic          timeout
);

  localparam int            CNT_TOP = (MAX_ON > MIN_ON) ? MAX_ON : MIN_ON;
  localparam int            CW      = cnt_width(CNT_TOP);
  localparam int            GW      = cnt_width(GAP);
  localparam logic [CW-1:0] MIN_M1  = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] MAX_M1  = CW'((MAX_ON == 0) ? 0 : MAX_ON - 1);
  localparam logic [GW-1:0] GAP_M1  = GW'((GAP == 0) ? 0 : GAP - 1);
  localparam logic [IW-1:0] LAST_ID = IW'(N - 1);

  if (!params_legal(N, MIN_ON, MAX_ON, GAP)) begin : g_param_check
    $error("onoff_rr_arbiter: illegal parameter set");
  end

  state_t        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;
  logic          max_hit;
  logic          hold_done;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Timeout wins over a voluntary release in the same cycle.
  assign max_hit   = (MAX_ON != 0) && (cnt == MAX_M1);
  assign hold_done = (cnt >= MIN_M1) && !req[gnt_id];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_OFF;
      gnt     <= '0;
      gnt_id  <= '0;
      out     <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
      gcnt    <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_OFF: begin
          if (pick_valid) begin
            gnt    <= pick_onehot;
            gnt_id <= pick_idx;
            out    <= 1'b1;
            busy   <= 1'b1;
            cnt    <= '0;
            state  <= S_ON;
          end
        end
        S_ON: begin
          if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
          if (max_hit || hold_done) begin
            gnt     <= '0;
            out     <= 1'b0;
            ptr     <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            timeout <= max_hit;
            gcnt    <= '0;
            if (GAP > 0) begin
              state <= S_GAP;
            end else begin
              busy  <= 1'b0;
              state <= S_OFF;
            end
          end
        end
        S_GAP: begin
          if (gcnt == GAP_M1) begin
            busy  <= 1'b0;
            state <= S_OFF;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: begin
          state <= S_OFF;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_onoff_rr_arbiter.sv
// ---- tb_onoff_rr_arbiter: directed scoreboard bench for onoff_rr_arbiter (rev 1.0) ----
`default_nettype none

module tb_onoff_rr_arbiter;

  localparam int N      = 4;
  localparam int MIN_ON = 3;
  localparam int MAX_ON = 8;
  localparam int GAP    = 2;
  localparam int IW     = 2;

  logic          clk;
  logic          resetn;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          out;
  logic          busy;
  logic          timeout;

  int vectors = 0;
  int errors  = 0;

  // One expected grant: owner, on-time, how it ends, and how the bench drives the owner.
  typedef struct {
    logic [N-1:0] gnt;
    int           id;
    int           len;
    bit           to;
    int           drop;
    bit           reraise;
    int           wait_cyc;
  } exp_t;

  exp_t sb[$];

  onoff_rr_arbiter #(
    .N      (N),
    .MIN_ON (MIN_ON),
    .MAX_ON (MAX_ON),
    .GAP    (GAP),
    .IW     (IW)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .out     (out),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic push(input logic [N-1:0] g, input int id, input int len, input bit to,
                      input int drop, input bit reraise, input int wait_cyc);
    exp_t e;
    e.gnt = g; e.id = id; e.len = len; e.to = to;
    e.drop = drop; e.reraise = reraise; e.wait_cyc = wait_cyc;
    sb.push_back(e);
  endtask

  // Waits for the next grant, checks it against the scoreboard head, then follows it through its gap.
  task automatic run_grant();
    exp_t e;
    int   w, len, g;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    w = 0;
    while (gnt === '0 && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (e.wait_cyc >= 0) chk("arb_latency", w, e.wait_cyc);
    chk("gnt", gnt, e.gnt);
    chk("gnt_id", gnt_id, e.id);
    len = 0;
    while (gnt === e.gnt && len < 20) begin
      len++;
      chk("one_owner", $countones(gnt), 1);
      chk("out_on", out, 1'b1);
      chk("busy_on", busy, 1'b1);
      if (len == e.drop) req[e.id] = 1'b0;
      @(negedge clk);
    end
    chk("on_time", len, e.len);
    chk("timeout_pulse", timeout, e.to);
    chk("out_off", out, 1'b0);
    chk("gnt_id_hold", gnt_id, e.id);
    g = 0;
    while (busy === 1'b1 && out === 1'b0 && g < 10) begin
      g++;
      if (g == 1 && e.reraise) req[e.id] = 1'b1;
      @(negedge clk);
    end
    chk("gap_len", g, GAP);
    chk("busy_off", busy, 1'b0);
    chk("timeout_once", timeout, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    req    = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_out", out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    resetn = 1'b1;
    @(negedge clk);

    // Min-on: a one-cycle request still gets three cycles, then ptr moves to 3.
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    push(4'b0100, 2, 3, 1'b0, -1, 1'b0, -1);
    run_grant();

    // Async reset mid-grant; afterwards ptr must be back at 0.
    req = 4'b1000;
    @(negedge clk);
    chk("pre_rst_gnt", gnt, 4'b1000);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_gnt", gnt, 4'b0000);
    chk("async_out", out, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_gnt_id", gnt_id, 0);
    @(negedge clk);
    resetn = 1'b1;
    req    = 4'b1001;
    push(4'b0001, 0, 3, 1'b0, 1, 1'b0, 1);
    push(4'b1000, 3, 3, 1'b0, 1, 1'b0, 1);
    run_grant();
    run_grant();

    // Round-robin with all requesting; owner 0 re-requests to close the circle.
    req = 4'b1111;
    push(4'b0001, 0, 4, 1'b0, 4, 1'b1, 1);
    push(4'b0010, 1, 4, 1'b0, 4, 1'b0, 1);
    push(4'b0100, 2, 4, 1'b0, 4, 1'b0, 1);
    push(4'b1000, 3, 4, 1'b0, 4, 1'b0, 1);
    push(4'b0001, 0, 4, 1'b0, 4, 1'b0, 1);
    repeat (5) run_grant();

    // Fairness: owner 1 times out under req=1011, next owner must be 3.
    req = 4'b1011;
    push(4'b0010, 1, 8, 1'b1, -1, 1'b0, 1);
    push(4'b1000, 3, 3, 1'b0, 1, 1'b0, 1);
    push(4'b0001, 0, 3, 1'b0, 1, 1'b0, 1);
    push(4'b0010, 1, 3, 1'b0, 1, 1'b0, 1);
    repeat (4) run_grant();

    // Timeout with a single held requester, then re-grant to the same one.
    req = 4'b0010;
    push(4'b0010, 1, 8, 1'b1, -1, 1'b0, 1);
    push(4'b0010, 1, 3, 1'b0, 1, 1'b0, 1);
    run_grant();
    run_grant();

    // Move ptr to 0 for the early-drop case.
    req = 4'b1000;
    push(4'b1000, 3, 3, 1'b0, 1, 1'b0, 1);
    run_grant();

    // Early drop by owner 0 while requester 2 waits.
    req = 4'b0101;
    push(4'b0001, 0, 3, 1'b0, 1, 1'b0, 1);
    push(4'b0100, 2, 3, 1'b0, 1, 1'b0, 1);
    run_grant();
    run_grant();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
